// File: rtl/inst_axi_bridge.sv
// Fetch-stage SRAM-like request to single-beat AXI4 read bridge, one read outstanding.
// Define INST_BUS_ERR_EN to report a non-OKAY rresp on inst_bus_err.
module inst_axi_bridge #(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              flush,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_bus_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                data_ok_q, data_ok_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                discard_q, discard_d;
  logic                accept_c;

  // Single beat, single ID: rid and rlast carry no information here.
  wire unused_ok = ^{rid, rlast, rresp};

  // A returned beat is delivered only if no flush hit this transaction, including this cycle.
  assign accept_c = (state_q == S_R) && rvalid && !discard_q && !flush;

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    discard_d = discard_q;
    case (state_q)
      S_IDLE: begin
        if (inst_req && !flush) begin
          addr_d    = iaddr;
          arvalid_d = 1'b1;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        if (flush) discard_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (flush) discard_d = 1'b1;
        if (rvalid) begin
          rready_d  = 1'b0;
          discard_d = 1'b0;
          state_d   = S_IDLE;
          if (accept_c) begin
            data_ok_d = 1'b1;
            rdata_d   = rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      discard_q <= discard_d;
    end
  end

`ifdef INST_BUS_ERR_EN
  logic bus_err_q, bus_err_d;

  // Error flag follows the delivered word and holds until the next delivery.
  always_comb begin
    bus_err_d = bus_err_q;
    if (accept_c) bus_err_d = (rresp != 2'b00);
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) bus_err_q <= 1'b0;
    else            bus_err_q <= bus_err_d;
  end

  assign inst_bus_err = bus_err_q;
`else
  assign inst_bus_err = 1'b0;
`endif

  assign inst_addr_ok = arvalid_q & arready;
  assign inst_data_ok = data_ok_q;
  assign inst_rdata   = rdata_q;
  assign arid         = AXI_ID;
  assign araddr       = addr_q;
  assign arlen        = 8'd0;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;

endmodule
